// File: rtl/cpu_trace_buffer_if.sv
// Trace buffer bus: CPU observation inputs, capture control and drain port.
// The master drives CPU state and control; the slave is the trace buffer.
interface cpu_trace_buffer_if #(
    parameter int unsigned INST_W  = 32,
    parameter int unsigned OPC_W   = 6,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned STATE_W = 3,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TS_W    = 16,
    parameter int unsigned POST_W  = 8
);
    localparam int unsigned REC_W = TS_W + 2*STATE_W + OPC_W + 3*REG_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [INST_W-1:0]  inst;
    logic               arm;
    logic [1:0]         mode;
    logic               trig_en;
    logic [OPC_W-1:0]   trig_opc;
    logic [POST_W-1:0]  post_cnt;
    logic               rd_en;
    logic [REC_W-1:0]   rd_data;
    logic               rd_valid;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               frozen;
    logic               busy;

    modport master (
        output state, next_state, inst, arm, mode, trig_en, trig_opc, post_cnt, rd_en,
        input  rd_data, rd_valid, count, overflow, frozen, busy
    );

    modport slave (
        input  state, next_state, inst, arm, mode, trig_en, trig_opc, post_cnt, rd_en,
        output rd_data, rd_valid, count, overflow, frozen, busy
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Trace recorder for the multicycle CPU: qualified capture into a circular
// buffer, frozen by an opcode trigger after a post window, drained oldest-first.
module cpu_trace_buffer #(
    parameter int unsigned INST_W   = 32,
    parameter int unsigned OPC_W    = 6,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned STATE_W  = 3,
    parameter int unsigned FETCH_ST = 0,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_W     = 16,
    parameter int unsigned POST_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    cpu_trace_buffer_if.slave   bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned REC_W = TS_W + 2*STATE_W + OPC_W + 3*REG_W;
    localparam int unsigned FLD_W = OPC_W + 3*REG_W;

    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [TS_W-1:0]    ts_q;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q, rd_valid_q, frozen_q, busy_q;
    logic [REC_W-1:0]   rd_data_q;
    logic [1:0]         mode_q;
    logic               trig_en_q;
    logic [OPC_W-1:0]   trig_opc_q;
    logic [POST_W-1:0]  post_q, post_d;

    logic [OPC_W-1:0]   opc_c;
    logic [REC_W-1:0]   rec_c;
    logic               qual_c, wr_c, rd_c, full_c, fetch_c;

    // The opcode and the three register fields are contiguous below the MSB.
    assign opc_c   = bus.inst[INST_W-1 -: OPC_W];
    assign rec_c   = {ts_q, bus.state, bus.next_state, bus.inst[INST_W-1 -: FLD_W]};
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign fetch_c = (bus.state == STATE_W'(FETCH_ST)) && (bus.next_state != STATE_W'(FETCH_ST));

    // Next-state logic; arm overrides capture and read.
    always_comb begin
        fsm_d  = fsm_q;
        post_d = post_q;
        qual_c = 1'b0;
        wr_c   = 1'b0;
        rd_c   = 1'b0;

        unique case (mode_q)
            2'b01:   qual_c = (bus.state != bus.next_state);
            2'b10:   qual_c = fetch_c;
            2'b11:   qual_c = 1'b1;
            default: qual_c = 1'b0;
        endcase

        if (bus.arm) begin
            fsm_d  = (bus.mode == 2'b00) ? IDLE : ARMED;
            post_d = bus.post_cnt;
        end else begin
            unique case (fsm_q)
                ARMED: begin
                    wr_c = qual_c;
                    if (qual_c && trig_en_q && (opc_c == trig_opc_q))
                        fsm_d = (post_q == '0) ? FROZEN : POST;
                end
                POST: begin
                    wr_c = qual_c;
                    if (qual_c) begin
                        post_d = post_q - POST_W'(1);
                        if (post_q == POST_W'(1))
                            fsm_d = FROZEN;
                    end
                end
                FROZEN:  rd_c = bus.rd_en && (count_q != '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= IDLE;
            post_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            post_q <= post_d;
        end
    end

    // Pointers, occupancy, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            frozen_q   <= 1'b0;
            busy_q     <= 1'b0;
            mode_q     <= 2'b00;
            trig_en_q  <= 1'b0;
            trig_opc_q <= '0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            rd_valid_q <= 1'b0;
            frozen_q   <= (fsm_d == FROZEN);
            busy_q     <= (fsm_d == ARMED) || (fsm_d == POST);
            if (bus.arm) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
                mode_q     <= bus.mode;
                trig_en_q  <= bus.trig_en;
                trig_opc_q <= bus.trig_opc;
            end else if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (full_c) begin
                    rd_ptr_q   <= rd_ptr_q + AW'(1);
                    overflow_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (rd_c) begin
                rd_data_q  <= mem[rd_ptr_q];
                rd_valid_q <= 1'b1;
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                count_q    <= count_q - CNT_W'(1);
            end
        end
    end

    // Record storage needs no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (!reset && wr_c)
            mem[wr_ptr_q] <= rec_c;
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.frozen   = frozen_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_cpu_trace_buffer;
    localparam int DEPTH = 16;
    localparam int PH_IDLE = 0, PH_ARMED = 1, PH_POST = 2, PH_FROZEN = 3;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    cpu_trace_buffer_if bus ();
    cpu_trace_buffer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: a plain queue of records plus the capture phase.
    logic [15:0] m_ts;
    logic [39:0] mq[$];
    bit          m_ovf, m_rv;
    logic [39:0] m_rd;
    int          m_ph;
    bit [1:0]    m_mode;
    bit          m_ten;
    logic [5:0]  m_topc;
    int          m_rem;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [39:0] r;
        bit q;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_rv = 0; m_rd = '0; m_ph = PH_IDLE; m_ts = '0;
            m_mode = 0; m_ten = 0; m_topc = '0; m_rem = 0;
        end else begin
            r = {m_ts, bus.state, bus.next_state, bus.inst[31:14]};
            m_ts = m_ts + 16'd1;
            m_rv = 0;
            if (bus.arm) begin
                mq.delete();
                m_ovf = 0;
                m_mode = bus.mode; m_ten = bus.trig_en; m_topc = bus.trig_opc;
                m_rem = int'(bus.post_cnt);
                m_ph = (bus.mode == 2'b00) ? PH_IDLE : PH_ARMED;
            end else if (m_ph == PH_ARMED || m_ph == PH_POST) begin
                q = (m_mode == 2'd1 && bus.state != bus.next_state) ||
                    (m_mode == 2'd2 && bus.state == 3'd0 && bus.next_state != 3'd0) ||
                    (m_mode == 2'd3);
                if (q) begin
                    mq.push_back(r);
                    if (mq.size() > DEPTH) begin
                        mq.delete(0);
                        m_ovf = 1;
                    end
                    if (m_ph == PH_POST) begin
                        m_rem--;
                        if (m_rem == 0) m_ph = PH_FROZEN;
                    end else if (m_ten && r[17:12] == m_topc) begin
                        m_ph = (m_rem == 0) ? PH_FROZEN : PH_POST;
                    end
                end
            end else if (m_ph == PH_FROZEN && bus.rd_en && mq.size() > 0) begin
                m_rd = mq.pop_front();
                m_rv = 1;
            end
        end
    endtask

    // One clock: model advances on current inputs, DUT sampled #1 after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        bus.arm = 1'b0;
        reset   = 1'b0;
        chk("count",    64'(bus.count),    64'(mq.size()));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("frozen",   64'(bus.frozen),   64'(m_ph == PH_FROZEN));
        chk("busy",     64'(bus.busy),     64'(m_ph == PH_ARMED || m_ph == PH_POST));
        chk("rd_valid", 64'(bus.rd_valid), 64'(m_rv));
        chk("rd_data",  64'(bus.rd_data),  64'(m_rd));
    endtask

    task automatic do_arm(input logic [1:0] md, input logic ten, input logic [5:0] opc,
                          input logic [7:0] pc);
        bus.arm = 1'b1; bus.mode = md; bus.trig_en = ten; bus.trig_opc = opc; bus.post_cnt = pc;
        step();
    endtask

    typedef struct {
        logic [2:0] st;
        logic [2:0] nst;
        int         exp_count;
        bit         exp_busy;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] arm_ts;
    logic [31:0] t3_inst;
    bit          exp_rv[4];
    int          exp_cnt[4];

    initial begin
        reset = 1'b1;
        bus.state = '0; bus.next_state = '0; bus.inst = '0; bus.arm = 1'b0;
        bus.mode = 2'b00; bus.trig_en = 1'b0; bus.trig_opc = '0; bus.post_cnt = '0;
        bus.rd_en = 1'b0;

        step();
        reset = 1'b1;
        step();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);

        // Mode 01 transitions: state 0->1->2->2->0.
        vecs[0] = '{3'd0, 3'd1, 1, 1'b1};
        vecs[1] = '{3'd1, 3'd2, 2, 1'b1};
        vecs[2] = '{3'd2, 3'd2, 2, 1'b1};
        vecs[3] = '{3'd2, 3'd0, 3, 1'b1};
        vecs[4] = '{3'd0, 3'd0, 3, 1'b1};
        bus.inst = 32'h1234_5678;
        do_arm(2'b01, 1'b0, 6'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            bus.state = vecs[i].st; bus.next_state = vecs[i].nst;
            step();
            chk("t1_count", 64'(bus.count), 64'(vecs[i].exp_count));
            chk("t1_busy",  64'(bus.busy),  64'(vecs[i].exp_busy));
            chk("t1_frozen", 64'(bus.frozen), 64'd0);
        end
        // Same sequence with a trigger on the first record, then drain next_state fields.
        bus.state = '0; bus.next_state = '0;
        do_arm(2'b01, 1'b1, bus.inst[31:26], 8'd2);
        for (int i = 0; i < 5; i++) begin
            bus.state = vecs[i].st; bus.next_state = vecs[i].nst;
            step();
        end
        chk("t1b_frozen", 64'(bus.frozen), 64'd1);
        bus.rd_en = 1'b1;
        step(); chk("t1b_ns0", 64'(bus.rd_data[20:18]), 64'd1);
        step(); chk("t1b_ns1", 64'(bus.rd_data[20:18]), 64'd2);
        step(); chk("t1b_ns2", 64'(bus.rd_data[20:18]), 64'd0);
        bus.rd_en = 1'b0;

        // Mode 11 overflow: 20 captures, trigger on the 20th with post_cnt 0.
        arm_ts = m_ts;
        bus.inst = 32'h0000_0000;
        do_arm(2'b11, 1'b1, 6'h3F, 8'd0);
        for (int i = 0; i < 20; i++) begin
            bus.inst = (i == 19) ? 32'hFC00_0000 : 32'h0400_0000;
            step();
        end
        chk("t2_count",    64'(bus.count),    64'd16);
        chk("t2_overflow", 64'(bus.overflow), 64'd1);
        chk("t2_frozen",   64'(bus.frozen),   64'd1);
        bus.rd_en = 1'b1;
        step();
        chk("t2_first_ts", 64'(bus.rd_data[39:24]), 64'(16'(arm_ts + 16'd5)));
        bus.rd_en = 1'b0;

        // Mode 10 fetch capture with decoded fields; freeze after 3 records.
        t3_inst = 32'b000000_1010_0101_1111_11110110010000;
        bus.state = 3'd0; bus.next_state = 3'd0;
        do_arm(2'b10, 1'b1, 6'b000000, 8'd2);
        bus.state = 3'd0; bus.next_state = 3'd1; bus.inst = t3_inst; step();
        bus.state = 3'd1; bus.next_state = 3'd2; bus.inst = 32'hFFFF_0000; step();
        bus.state = 3'd0; bus.next_state = 3'd1; step();
        chk("t3_frozen_early", 64'(bus.frozen), 64'd0);
        step();
        chk("t3_frozen", 64'(bus.frozen), 64'd1);
        chk("t3_count",  64'(bus.count),  64'd3);

        // Four back-to-back reads with only three entries held.
        exp_rv  = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_cnt = '{2, 1, 0, 0};
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_rd_valid", 64'(bus.rd_valid), 64'(exp_rv[i]));
            chk("t4_count",    64'(bus.count),    64'(exp_cnt[i]));
            if (i == 0) begin
                chk("t3_opc", 64'(bus.rd_data[17:12]), 64'd0);
                chk("t3_rd",  64'(bus.rd_data[11:8]),  64'hA);
                chk("t3_rs1", 64'(bus.rd_data[7:4]),   64'h5);
                chk("t3_rs2", 64'(bus.rd_data[3:0]),   64'hF);
            end
        end
        bus.rd_en = 1'b0;

        // Read attempt while ARMED, then disarm with mode 00.
        do_arm(2'b01, 1'b0, 6'd0, 8'd0);
        bus.state = 3'd1; bus.next_state = 3'd2; step();
        bus.state = 3'd2; bus.next_state = 3'd2; bus.rd_en = 1'b1; step();
        chk("t5_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("t5_count",    64'(bus.count),    64'd1);
        bus.rd_en = 1'b0;
        do_arm(2'b00, 1'b0, 6'd0, 8'd0);
        chk("t5_busy",  64'(bus.busy),  64'd0);
        chk("t5_count_idle", 64'(bus.count), 64'd0);

        // Reset together with arm in the middle of POST.
        bus.inst = 32'hA800_0000;
        do_arm(2'b11, 1'b1, 6'h2A, 8'd10);
        step(); step(); step();
        chk("t6_busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b1; bus.arm = 1'b1; bus.mode = 2'b11;
        step();
        chk("t6_count",    64'(bus.count),    64'd0);
        chk("t6_busy",     64'(bus.busy),     64'd0);
        chk("t6_overflow", 64'(bus.overflow), 64'd0);
        chk("t6_rd_data",  64'(bus.rd_data),  64'd0);
        step();
        chk("t6_idle_count", 64'(bus.count), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.state      = 3'($urandom_range(0, 3));
            bus.next_state = 3'($urandom_range(0, 3));
            bus.inst       = {6'($urandom_range(0, 3)), 26'($urandom)};
            bus.rd_en      = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 39) == 0) begin
                bus.arm      = 1'b1;
                bus.mode     = 2'($urandom_range(0, 3));
                bus.trig_en  = ($urandom_range(0, 3) != 0);
                bus.trig_opc = 6'($urandom_range(0, 3));
                bus.post_cnt = 8'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Parametrised on-chip trace recorder for the multicycle RISC CPU. It watches the control FSM state and the fetched instruction, and captures decoded records into a circular buffer of configurable depth. Capture can be qualified by mode and frozen by an opcode trigger with a programmable post-trigger window. The frozen buffer is then drained oldest-first. It sits beside `cpu` as debug infrastructure, replacing one-shot printing of state and decode fields with a cycle-stamped history.

## Interface
Parameters:
- `INST_W`, 32, instruction width
- `OPC_W`, 6, opcode field width (`inst[INST_W-1 -: OPC_W]`)
- `REG_W`, 4, register field width; fields below the opcode, in order: rd, rs1, rs2
- `STATE_W`, 3, CPU FSM state width
- `FETCH_ST`, 0, encoding of the CPU fetch state
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `TS_W`, 16, timestamp width
- `POST_W`, 8, post-trigger counter width
- Record width: `REC_W = TS_W + 2*STATE_W + OPC_W + 3*REG_W`, packed MSB→LSB as {ts, state, next_state, opcode, rd, rs1, rs2}

Ports:
- `clk`  in  1  clock; all logic is rising-edge
- `reset`  in  1  synchronous reset, active-high
- `state`  in  STATE_W  current CPU state
- `next_state`  in  STATE_W  CPU next state
- `inst`  in  INST_W  current instruction
- `arm`  in  1  single-cycle pulse; clears the buffer and starts capture
- `mode`  in  2  sampled on `arm`: 00 off, 01 state transitions, 10 fetch only, 11 every cycle
- `trig_en`  in  1  sampled on `arm`; enables the opcode trigger
- `trig_opc`  in  OPC_W  sampled on `arm`; trigger opcode
- `post_cnt`  in  POST_W  sampled on `arm`; records to capture after the trigger record
- `rd_en`  in  1  pops the oldest record; honoured only in FROZEN
- `rd_data`  out  REC_W  popped record
- `rd_valid`  out  1  `rd_data` valid, one-cycle pulse
- `count`  out  $clog2(DEPTH)+1  entries held
- `overflow`  out  1  sticky; set when an entry was overwritten since the last arm
- `frozen`  out  1  high in FROZEN
- `busy`  out  1  high in ARMED or POST

## Operation
- FSM states: IDLE, ARMED, POST, FROZEN. Reset state is IDLE.
- A free-running timestamp counter increments every cycle and wraps modulo 2^TS_W. It resets to 0 and is not cleared by `arm`.
- `arm` in any state clears `count`, the pointers, `overflow` and `rd_valid`, and latches `mode`, `trig_en`, `trig_opc` and `post_cnt`.
  - `mode`=00: go to IDLE.
  - Otherwise: go to ARMED.
- Qualifying cycle, evaluated in ARMED and POST only:
  - mode 01: `state != next_state`
  - mode 10: `state == FETCH_ST && next_state != FETCH_ST`
  - mode 11: every cycle
- Each qualifying cycle writes one record at the write pointer, then advances the pointer modulo DEPTH.
  - When `count < DEPTH`, `count` increments.
  - When `count == DEPTH`, the oldest entry is overwritten: the read pointer advances, `count` stays at DEPTH, and `overflow` is set.
- Trigger handling:
  - ARMED→POST when a record is written, `trig_en`=1, and its opcode equals `trig_opc`.
  - If `post_cnt`=0, go straight to FROZEN instead.
  - In POST, each further record decrements the remaining count. The write that takes it to 0 moves the FSM to FROZEN.
- With `trig_en`=0, the FSM stays in ARMED until the next `arm`.
- FROZEN: no capture. `rd_en` with `count>0` outputs the entry at the read pointer, advances the pointer, and decrements `count`.
- `rd_en` with `count==0`, or `rd_en` outside FROZEN: ignored, and `rd_valid` stays 0.
- Precedence: `reset` > `arm` > capture or read.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `count`=0, `overflow`=0, `frozen`=0, `busy`=0.
- A qualifying cycle N is written at the edge ending cycle N. The record holds the `ts`, `state`, `next_state` and `inst` values from cycle N. The updated `count` is visible in cycle N+1.
- `rd_en` in cycle N gives `rd_data` and `rd_valid`=1 in cycle N+1. `rd_data` holds its value after the pulse. Back-to-back `rd_en` gives one record per cycle.
- `frozen` rises in the cycle after the final write. `busy` rises in the cycle after `arm`.
- Reset mid-capture or mid-read: everything returns to reset values on the next edge, and buffer contents are discarded (`count`=0).
- A timestamp wrap is not flagged. Records stay ordered by buffer position, not by timestamp.

## Test plan
- Reset, then `arm` with mode=01 and `trig_en`=0. Drive state 0→1→2→2→0, one change per cycle except the hold. Result: `count`=3, `busy`=1, `frozen`=0, and records carry next_state 1, 2, 0.
- Mode=11, DEPTH=16, 20 cycles of capture, then trigger on the last cycle with `post_cnt`=0. Result: `count`=16, `overflow`=1, and the first popped `ts` is 4 greater than the arm-cycle value plus 1.
- Mode=10, `trig_opc`=6'b000000, `post_cnt`=2, with `inst`=32'b000000_1010_0101_1111_11110110010000 fetched. Result: the first record has opcode=0, rd=4'b1010, rs1=4'b0101, rs2=4'b1111. `frozen` is set after 3 records.
- While FROZEN with `count`=3: `rd_en` for 4 consecutive cycles. Result: `rd_valid`=1,1,1,0 and `count` goes 2,1,0,0.
- `rd_en` while ARMED. Result: `rd_valid`=0 and `count` is unchanged. Then `arm` with mode=00. Result: IDLE, `count`=0, `busy`=0.
- Assert `reset` in the same cycle as `arm`, midway through POST. Result: all outputs are 0 next cycle and the FSM is in IDLE.
